// File: rtl/ddr_local_pkg.sv
// ddr_local_pkg
// Shared definitions for the DDR local-interface responder: the controller
// state enum, data/byte-enable widths and the stall LFSR seed, taps and
// next-state helper. The LFSR items only matter when the top is built with
// DDR_LOCAL_RESPONDER_STALL_EN defined.
package ddr_local_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB, so the taps
  // sit on bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WRITE,
    READ_WAIT,
    READ_DATA
  } state_e;

  function automatic logic [15:0] lfsrNext(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ddr_local_mem.sv
// ddr_local_mem
// Single-port word RAM (2^MEM_AW x 32) with per-byte write enables and a
// registered read port (one cycle from re_i to rdata_o).
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset (read register only)
//   addr_i          word address shared by read and write
//   we_i, be_i      write strobe and byte enables
//   wdata_i         write data
//   re_i            read strobe; rdata_o updates on the next edge
//   rdata_o         registered read data
module ddr_local_mem
  import ddr_local_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [MEM_AW-1:0]     addr_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array is deliberately left out of reset so it behaves like the
  // DDR device it replaces and maps onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (we_i && be_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read data only changes on a read strobe so the output holds the last
  // beat between bursts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ddr_local_responder.sv
// ddr_local_responder
// Behavioural stand-in for a vendor DDR controller local interface plus the
// DDR device. Accepts burst writes (with byte enables) and burst reads with
// a fixed READ_LATENCY, and raises local_init_done_o INIT_CYCLES edges after
// reset release. Optional macro DDR_LOCAL_RESPONDER_STALL_EN enables
// pseudo-random ready stalls driven by a 16-bit LFSR.
// Ports:
//   local_clk_i, local_reset_n_i   clock, asynchronous active-low reset
//   local_address_i, local_size_i  burst start word address and beat count
//   local_write_req_i              write beat request
//   local_read_req_i               read command request
//   local_burstbegin_i             first-beat marker
//   local_wdata_i, local_be_i      write data and byte enables
//   local_ready_o                  request accepted this cycle
//   local_rdata_o                  read data
//   local_rdata_valid_o            read data valid
//   local_init_done_o              initialization complete
//   protocol_err_o                 sticky protocol violation flag
module ddr_local_responder
  import ddr_local_pkg::*;
#(
  parameter int ADDR_WIDTH   = 23,
  parameter int SIZE_WIDTH   = 7,
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 4,
  parameter int INIT_CYCLES  = 16
) (
  input  logic                  local_clk_i,
  input  logic                  local_reset_n_i,
  input  logic [ADDR_WIDTH-1:0] local_address_i,
  input  logic                  local_write_req_i,
  input  logic                  local_read_req_i,
  input  logic                  local_burstbegin_i,
  input  logic [DATA_WIDTH-1:0] local_wdata_i,
  input  logic [BE_WIDTH-1:0]   local_be_i,
  input  logic [SIZE_WIDTH-1:0] local_size_i,
  output logic                  local_ready_o,
  output logic [DATA_WIDTH-1:0] local_rdata_o,
  output logic                  local_rdata_valid_o,
  output logic                  local_init_done_o,
  output logic                  protocol_err_o
);

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [INIT_W-1:0]     initCnt_q, initCnt_d;
  logic                  initDone_q, initDone_d;
  logic                  err_q, err_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] beatsLeft_q, beatsLeft_d;
  logic [3:0]            waitCnt_q, waitCnt_d;

  logic                  stall;
  logic                  ready;
  logic [SIZE_WIDTH-1:0] sizeEff;
  logic [MEM_AW-1:0]     memAddr;
  logic                  memWe;
  logic                  memRe;
  logic                  unusedAddrHi;

  assign unusedAddrHi = ^local_address_i[ADDR_WIDTH-1:MEM_AW];

`ifdef DDR_LOCAL_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running LFSR; a 2'b00 in its low bits blocks acceptance roughly a
  // quarter of the time.
  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsrNext(lfsr_q);
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ready depends only on registered state, never on the request inputs.
  assign ready   = ((state_q == IDLE) || (state_q == WRITE)) && !stall;
  assign sizeEff = (local_size_i == '0) ? SIZE_WIDTH'(1) : local_size_i;

  always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
    if (!local_reset_n_i) begin
      state_q     <= INIT;
      initCnt_q   <= '0;
      initDone_q  <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      beatsLeft_q <= '0;
      waitCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      initCnt_q   <= initCnt_d;
      initDone_q  <= initDone_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      beatsLeft_q <= beatsLeft_d;
      waitCnt_q   <= waitCnt_d;
    end
  end

  // READ_WAIT lasts READ_LATENCY-1 cycles; the RAM read for the first beat
  // is issued in its final cycle so the RAM's own register stage lines up
  // with the first READ_DATA cycle. Each READ_DATA cycle then prefetches the
  // following beat. addr_q always holds the next word to touch.
  always_comb begin
    state_d     = state_q;
    initCnt_d   = initCnt_q;
    initDone_d  = initDone_q;
    err_d       = err_q;
    addr_d      = addr_q;
    beatsLeft_d = beatsLeft_q;
    waitCnt_d   = waitCnt_q;
    memAddr     = addr_q;
    memWe       = 1'b0;
    memRe       = 1'b0;

    case (state_q)
      INIT: begin
        if (initCnt_q == INIT_W'(INIT_CYCLES - 1)) begin
          initDone_d = 1'b1;
          state_d    = IDLE;
        end else begin
          initCnt_d = initCnt_q + INIT_W'(1);
        end
      end

      IDLE: begin
        memAddr = local_address_i[MEM_AW-1:0];
        if (local_write_req_i && local_read_req_i) begin
          err_d = 1'b1;
        end
        if (ready && (local_write_req_i || local_read_req_i)) begin
          if ((local_size_i == '0) || !local_burstbegin_i) begin
            err_d = 1'b1;
          end
          if (local_write_req_i) begin
            memWe  = 1'b1;
            addr_d = local_address_i[MEM_AW-1:0] + MEM_AW'(1);
            if (sizeEff != SIZE_WIDTH'(1)) begin
              beatsLeft_d = sizeEff - SIZE_WIDTH'(1);
              state_d     = WRITE;
            end
          end else begin
            addr_d      = local_address_i[MEM_AW-1:0];
            beatsLeft_d = sizeEff;
            waitCnt_d   = 4'(READ_LATENCY - 2);
            state_d     = READ_WAIT;
          end
        end
      end

      WRITE: begin
        if (local_read_req_i) begin
          err_d = 1'b1;
        end
        if (ready && local_write_req_i) begin
          memWe       = 1'b1;
          addr_d      = addr_q + MEM_AW'(1);
          beatsLeft_d = beatsLeft_q - SIZE_WIDTH'(1);
          if (beatsLeft_q == SIZE_WIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end

      READ_WAIT: begin
        if (waitCnt_q == 4'd0) begin
          memRe   = 1'b1;
          addr_d  = addr_q + MEM_AW'(1);
          state_d = READ_DATA;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end

      READ_DATA: begin
        beatsLeft_d = beatsLeft_q - SIZE_WIDTH'(1);
        if (beatsLeft_q > SIZE_WIDTH'(1)) begin
          memRe  = 1'b1;
          addr_d = addr_q + MEM_AW'(1);
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = INIT;
    endcase
  end

  ddr_local_mem #(
    .MEM_AW(MEM_AW)
  ) u_mem (
    .clk_i  (local_clk_i),
    .rst_n_i(local_reset_n_i),
    .addr_i (memAddr),
    .we_i   (memWe),
    .be_i   (local_be_i),
    .wdata_i(local_wdata_i),
    .re_i   (memRe),
    .rdata_o(local_rdata_o)
  );

  assign local_ready_o       = ready;
  assign local_rdata_valid_o = (state_q == READ_DATA);
  assign local_init_done_o   = initDone_q;
  assign protocol_err_o      = err_q;

endmodule

// File: tb/tb_ddr_local_responder.sv
// tb_ddr_local_responder
// Self-checking bench for ddr_local_responder: directed bursts plus random
// write/read traffic compared against a word-array memory model.
module tb_ddr_local_responder;

  localparam int ADDR_WIDTH   = 23;
  localparam int SIZE_WIDTH   = 7;
  localparam int MEM_AW       = 10;
  localparam int READ_LATENCY = 4;
  localparam int INIT_CYCLES  = 16;
  localparam int DEPTH        = 1 << MEM_AW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [ADDR_WIDTH-1:0] address;
  logic                  writeReq;
  logic                  readReq;
  logic                  burstBegin;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic [SIZE_WIDTH-1:0] size;
  logic                  ready;
  logic [31:0]           rdata;
  logic                  rdataValid;
  logic                  initDone;
  logic                  protocolErr;

  ddr_local_responder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SIZE_WIDTH  (SIZE_WIDTH),
    .MEM_AW      (MEM_AW),
    .READ_LATENCY(READ_LATENCY),
    .INIT_CYCLES (INIT_CYCLES)
  ) dut (
    .local_clk_i        (clk),
    .local_reset_n_i    (rst_n),
    .local_address_i    (address),
    .local_write_req_i  (writeReq),
    .local_read_req_i   (readReq),
    .local_burstbegin_i (burstBegin),
    .local_wdata_i      (wdata),
    .local_be_i         (be),
    .local_size_i       (size),
    .local_ready_o      (ready),
    .local_rdata_o      (rdata),
    .local_rdata_valid_o(rdataValid),
    .local_init_done_o  (initDone),
    .protocol_err_o     (protocolErr)
  );

  always #5 clk = ~clk;

  // Reference memory: word contents plus a flag saying the whole word is
  // known (only then is a read of it checked).
  logic [31:0] model [DEPTH];
  bit          known [DEPTH];
  logic [31:0] burstData [128];
  logic [3:0]  burstBe [128];
  logic [31:0] readData [128];

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic idleInputs();
    address    = '0;
    writeReq   = 1'b0;
    readReq    = 1'b0;
    burstBegin = 1'b0;
    wdata      = '0;
    be         = '0;
    size       = '0;
  endtask

  task automatic modelWrite(input int a, input logic [31:0] d, input logic [3:0] bEn);
    for (int b = 0; b < 4; b++) begin
      if (bEn[b]) model[a][8*b +: 8] = d[8*b +: 8];
    end
    if (bEn == 4'hF) known[a] = 1'b1;
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) checkOutput("readyTimeout", 32'(ready), 32'd1);
  endtask

  task automatic waitInit();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!initDone && n < 64);
    checkOutput("initEdges", 32'(n), 32'(INIT_CYCLES));
    checkOutput("readyAtInit", 32'(ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstValid", 32'(rdataValid), 32'd0);
    checkOutput("rstReady", 32'(ready), 32'd0);
    checkOutput("rstInitDone", 32'(initDone), 32'd0);
    checkOutput("rstErr", 32'(protocolErr), 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitInit();
  endtask

  // Beats after the first carry junk address/size, which must be ignored.
  task automatic applyStimulus(input logic [ADDR_WIDTH-1:0] addr, input int sz,
                               input bit bb, input bit withRead, input int readBeat);
    int n = (sz == 0) ? 1 : sz;
    bit ok;
    for (int k = 0; k < n; k++) begin
      writeReq   = 1'b1;
      readReq    = withRead && (k == readBeat);
      burstBegin = (k == 0) ? bb : 1'b0;
      address    = (k == 0) ? addr : ADDR_WIDTH'($urandom);
      size       = (k == 0) ? SIZE_WIDTH'(sz) : SIZE_WIDTH'($urandom);
      wdata      = burstData[k];
      be         = burstBe[k];
      waitReady(ok);
      if (!ok) begin
        idleInputs();
        return;
      end
      @(posedge clk);
      modelWrite((int'(addr[MEM_AW-1:0]) + k) % DEPTH, burstData[k], burstBe[k]);
      @(negedge clk);
    end
    idleInputs();
  endtask

  task automatic readBurst(input logic [ADDR_WIDTH-1:0] addr, input int sz);
    int n = (sz == 0) ? 1 : sz;
    int lat;
    int a;
    bit ok;
    readReq    = 1'b1;
    burstBegin = 1'b1;
    address    = addr;
    size       = SIZE_WIDTH'(sz);
    waitReady(ok);
    if (!ok) begin
      idleInputs();
      return;
    end
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    lat = 1;
    while (!rdataValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("readLatency", 32'(lat), 32'(READ_LATENCY));
    if (!rdataValid) return;
    for (int k = 0; k < n; k++) begin
      a = (int'(addr[MEM_AW-1:0]) + k) % DEPTH;
      readData[k] = rdata;
      checkOutput("rdValid", 32'(rdataValid), 32'd1);
      if (known[a]) checkOutput($sformatf("rdata[%03h]", a), rdata, model[a]);
      @(negedge clk);
    end
    checkOutput("validEnd", 32'(rdataValid), 32'd0);
    checkOutput("readyAfterRead", 32'(ready), 32'd1);
  endtask

  task automatic fillBurst(input int n, input bit fullBe);
    for (int k = 0; k < n; k++) begin
      burstData[k] = $urandom;
      burstBe[k]   = fullBe ? 4'hF : 4'($urandom);
    end
  endtask

  initial begin
    logic [ADDR_WIDTH-1:0] base;
    int s1;
    int s2;
    int off;
    int lat;

    idleInputs();
    doReset();

    // Basic burst at 0x10.
    for (int k = 0; k < 4; k++) begin
      burstData[k] = 32'hA0 + 32'(k);
      burstBe[k]   = 4'hF;
    end
    applyStimulus(23'h10, 4, 1'b1, 1'b0, 0);
    readBurst(23'h10, 4);
    checkOutput("burstBeat0", readData[0], 32'hA0);
    checkOutput("burstBeat3", readData[3], 32'hA3);

    // Byte-enable merge.
    burstData[0] = 32'hFFFF_FFFF;
    burstBe[0]   = 4'hF;
    applyStimulus(23'h5, 1, 1'b1, 1'b0, 0);
    burstData[0] = 32'h1122_3344;
    burstBe[0]   = 4'b0101;
    applyStimulus(23'h5, 1, 1'b1, 1'b0, 0);
    readBurst(23'h5, 1);
    checkOutput("beMerge", readData[0], 32'hFF22_FF44);

    // Address wrap at the top of the RAM.
    for (int k = 0; k < 4; k++) begin
      burstData[k] = 32'hC0DE_0000 + 32'(k);
      burstBe[k]   = 4'hF;
    end
    applyStimulus(23'h3FE, 4, 1'b1, 1'b0, 0);
    readBurst(23'h0, 2);
    checkOutput("wrapWord0", readData[0], 32'hC0DE_0002);
    checkOutput("wrapWord1", readData[1], 32'hC0DE_0003);
    readBurst(23'h3FE, 4);

    // One long burst.
    fillBurst(100, 1'b1);
    applyStimulus(23'h140, 100, 1'b1, 1'b0, 0);
    readBurst(23'h140, 100);

    // Random overlapping traffic.
    for (int it = 0; it < 10; it++) begin
      base = ADDR_WIDTH'($urandom);
      s1   = $urandom_range(1, 16);
      fillBurst(s1, 1'b1);
      applyStimulus(base, s1, 1'b1, 1'b0, 0);
      off = $urandom_range(0, s1 - 1);
      s2  = $urandom_range(1, 8);
      fillBurst(s2, 1'b0);
      applyStimulus(base + ADDR_WIDTH'(off), s2, 1'b1, 1'b0, 0);
      readBurst(base, s1 + s2);
    end
    checkOutput("errClean", 32'(protocolErr), 32'd0);

    // Write and read requested together: write wins.
    burstData[0] = 32'h5A5A_0001;
    burstBe[0]   = 4'hF;
    applyStimulus(23'h200, 1, 1'b1, 1'b1, 0);
    checkOutput("errBothReq", 32'(protocolErr), 32'd1);
    checkOutput("noReadBothReq", 32'(rdataValid), 32'd0);
    readBurst(23'h200, 1);
    checkOutput("errSticky", 32'(protocolErr), 32'd1);
    doReset();

    // Size zero acts as a single beat.
    burstData[0] = 32'h5A5A_0002;
    burstBe[0]   = 4'hF;
    applyStimulus(23'h210, 0, 1'b1, 1'b0, 0);
    checkOutput("errSizeZero", 32'(protocolErr), 32'd1);
    readBurst(23'h210, 2);
    doReset();

    // Missing burstbegin on the first beat.
    fillBurst(2, 1'b1);
    applyStimulus(23'h220, 2, 1'b0, 1'b0, 0);
    checkOutput("errNoBurstBegin", 32'(protocolErr), 32'd1);
    readBurst(23'h220, 2);
    doReset();

    // Read request during a write burst is ignored.
    fillBurst(3, 1'b1);
    applyStimulus(23'h230, 3, 1'b1, 1'b1, 1);
    checkOutput("errReadInWrite", 32'(protocolErr), 32'd1);
    checkOutput("noReadInWrite", 32'(rdataValid), 32'd0);
    readBurst(23'h230, 3);

    // Reset in the middle of a read burst.
    readReq    = 1'b1;
    burstBegin = 1'b1;
    address    = 23'h10;
    size       = SIZE_WIDTH'(8);
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    lat = 0;
    while (!rdataValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("midReadValid", 32'(rdataValid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortValid", 32'(rdataValid), 32'd0);
    checkOutput("abortReady", 32'(ready), 32'd0);
    checkOutput("abortInitDone", 32'(initDone), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitInit();
    readBurst(23'h10, 4);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
